// File: rtl/scr1_tcm_pkg.sv
// Shared types, collision-policy constants and the byte-lane merge helper
// for the SCR1 dual-port TCM.
package scr1_tcm_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } tcm_ld_state_e;

    localparam int COLL_READ_FIRST  = 0;
    localparam int COLL_WRITE_FIRST = 1;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/scr1_tcm_rd_pipe.sv
// Read-return pipeline of RD_LAT register stages; the last stage holds its data
// when nothing is returned, and every valid bit is cleared by reset.
module scr1_tcm_rd_pipe
    import scr1_tcm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o,
    output logic             vld_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [WIDTH-1:0]  data_q [RD_LAT];

    // shift data/valid down the stages, loading data only on a valid beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= req_i;
            if (req_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign q_o   = data_q[RD_LAT-1];
    assign vld_o = vld_q[RD_LAT-1];

endmodule

// File: rtl/scr1_tcm_dp_ram.sv
// Dual-port TCM: port A read-only, port B read/write with byte enables, plus a
// streaming loader that fills words 0..INIT_WORDS-1 before the ports go live.
module scr1_tcm_dp_ram
    import scr1_tcm_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH_WORDS    = 16384,
    parameter int NBYTES         = WIDTH / 8,
    parameter int RD_LAT         = 1,
    parameter int COLLISION_MODE = COLL_READ_FIRST,
    parameter int INIT_WORDS     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rena,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addra,
    output logic [WIDTH-1:0]               qa,
    output logic                           qa_vld,
    input  logic                           renb,
    input  logic                           wenb,
    input  logic [NBYTES-1:0]              webb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addrb,
    input  logic [WIDTH-1:0]               datab,
    output logic [WIDTH-1:0]               qb,
    output logic                           qb_vld,
    input  logic                           ld_valid,
    input  logic [WIDTH-1:0]               ld_data,
    output logic                           ld_ready,
    output logic                           init_done
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LD_LAST = (INIT_WORDS == 0) ? '0 : AW'(INIT_WORDS - 1);

    logic [WIDTH-1:0] mem_q [DEPTH_WORDS];

    tcm_ld_state_e   state_q, state_d;
    logic [AW-1:0]   ld_cnt_q, ld_cnt_d;
    logic            ld_ready_q, ld_ready_d;
    logic            init_done_q, init_done_d;

    logic            ld_acc_s;
    logic            rd_a_s, rd_b_s, wr_b_s;
    logic            hit_a_s, hit_b_s;
    logic            wr_en_s;
    logic [AW-1:0]   wr_addr_s;
    logic [WIDTH-1:0] wr_data_s;
    logic [NBYTES-1:0] wr_be_s;
    logic [WIDTH-1:0] rdata_a_s, rdata_b_s;

    // Port traffic is gated on the registered init_done, so nothing reaches the
    // array from A/B until the cycle after the final loader word.
    assign ld_acc_s = (state_q == LOAD) && ld_ready_q && ld_valid;
    assign rd_a_s   = init_done_q && rena;
    assign rd_b_s   = init_done_q && renb;
    assign wr_b_s   = init_done_q && wenb;

    // FSM state, loader counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LOAD;
            ld_cnt_q    <= '0;
            ld_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            ld_ready_q  <= ld_ready_d;
            init_done_q <= init_done_d;
        end
    end

    // next state: count accepted loader words, leave LOAD after the last one
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        case (state_q)
            LOAD: begin
                if (INIT_WORDS == 0) begin
                    state_d = RUN;
                end else if (ld_acc_s) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == LD_LAST) begin
                        state_d = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = LOAD;
        endcase
    end

    // outputs follow the upcoming state so they can be registered
    always_comb begin
        ld_ready_d  = (state_d == LOAD) && (INIT_WORDS != 0);
        init_done_d = (state_d == RUN);
    end

    // single write port shared by the loader (LOAD only) and port B (RUN only)
    always_comb begin
        if (ld_acc_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ld_cnt_q;
            wr_data_s = ld_data;
            wr_be_s   = '1;
        end else if (wr_b_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addrb;
            wr_data_s = datab;
            wr_be_s   = webb;
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = addrb;
            wr_data_s = datab;
            wr_be_s   = '0;
        end
    end

    // byte-lane array write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be_s[i]) begin
                    mem_q[wr_addr_s][i*8 +: 8] <= wr_data_s[i*8 +: 8];
                end
            end
        end
    end

    // The array is read before this cycle's write lands, which is read-first by
    // construction; write-first overlays the enabled bytes of datab on a hit.
    assign hit_a_s = (COLLISION_MODE == COLL_WRITE_FIRST) && wr_b_s && (addra == addrb);
    assign hit_b_s = (COLLISION_MODE == COLL_WRITE_FIRST) && wr_b_s;

    // collision-aware read data for both ports
    always_comb begin
        rdata_a_s = '0;
        rdata_b_s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            rdata_a_s[i*8 +: 8] = byte_merge(mem_q[addra][i*8 +: 8], datab[i*8 +: 8],
                                             webb[i] && hit_a_s);
            rdata_b_s[i*8 +: 8] = byte_merge(mem_q[addrb][i*8 +: 8], datab[i*8 +: 8],
                                             webb[i] && hit_b_s);
        end
    end

    scr1_tcm_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .req_i  (rd_a_s),
        .data_i (rdata_a_s),
        .q_o    (qa),
        .vld_o  (qa_vld)
    );

    scr1_tcm_rd_pipe #(.WIDTH(WIDTH), .RD_LAT(RD_LAT)) u_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .req_i  (rd_b_s),
        .data_i (rdata_b_s),
        .q_o    (qb),
        .vld_o  (qb_vld)
    );

    assign ld_ready  = ld_ready_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_scr1_tcm_dp_ram.sv
// Bench for scr1_tcm_dp_ram: three configurations share one directed stimulus and
// are checked every cycle against a word-level memory model plus literal expectations.
module tb_scr1_tcm_dp_ram;

    localparam int NI    = 3;
    localparam int DEPTH = 64;

    // per-instance configuration: {RD_LAT, COLLISION_MODE, INIT_WORDS}
    int p_lat  [NI] = '{1, 2, 1};
    int p_mode [NI] = '{0, 1, 1};
    int p_init [NI] = '{4, 4, 0};

    logic        clk = 1'b0;
    logic        rst, rena, renb, wenb, ld_valid;
    logic [5:0]  addra, addrb;
    logic [3:0]  webb;
    logic [31:0] datab, ld_data;

    logic [31:0] qa_w [NI];
    logic [31:0] qb_w [NI];
    logic        qa_vld_w [NI];
    logic        qb_vld_w [NI];
    logic        ld_ready_w [NI];
    logic        init_done_w [NI];

    always #5 clk = ~clk;

    scr1_tcm_dp_ram #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .COLLISION_MODE(0), .INIT_WORDS(4)) u0 (
        .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa_w[0]), .qa_vld(qa_vld_w[0]),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb_w[0]),
        .qb_vld(qb_vld_w[0]), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_w[0]),
        .init_done(init_done_w[0]));

    scr1_tcm_dp_ram #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .RD_LAT(2), .COLLISION_MODE(1), .INIT_WORDS(4)) u1 (
        .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa_w[1]), .qa_vld(qa_vld_w[1]),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb_w[1]),
        .qb_vld(qb_vld_w[1]), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_w[1]),
        .init_done(init_done_w[1]));

    scr1_tcm_dp_ram #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .COLLISION_MODE(1), .INIT_WORDS(0)) u2 (
        .clk(clk), .rst(rst), .rena(rena), .addra(addra), .qa(qa_w[2]), .qa_vld(qa_vld_w[2]),
        .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab), .qb(qb_w[2]),
        .qb_vld(qb_vld_w[2]), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_w[2]),
        .init_done(init_done_w[2]));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] d;
        bit          kn;
    } ret_t;

    int          m_cyc = 0;
    bit          m_live = 1'b0;
    logic [31:0] m_mem [NI][DEPTH];
    bit          m_kn  [NI][DEPTH];
    int          m_cnt [NI];
    bit          m_ready [NI];
    bit          m_done  [NI];
    ret_t        pend  [2*NI][$];
    logic [31:0] e_q   [2*NI];
    bit          e_kn  [2*NI];
    bit          e_vld [2*NI];

    function automatic logic [31:0] merge32(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic ret_t read_word(input int k, input logic [5:0] a, input int due);
        ret_t r;
        r.due = due;
        r.d   = m_mem[k][a];
        r.kn  = m_kn[k][a];
        if (p_mode[k] == 1 && wenb && addrb == a) r.d = merge32(r.d, datab, webb);
        return r;
    endfunction

    task automatic model_step();
        ret_t r;
        if (rst !== 1'b1) begin
            m_live = 1'b1;
            for (int k = 0; k < NI; k++) begin
                m_cnt[k] = 0; m_ready[k] = 1'b0; m_done[k] = 1'b0;
            end
            for (int j = 0; j < 2*NI; j++) begin
                pend[j].delete(); e_q[j] = 32'h0; e_kn[j] = 1'b1; e_vld[j] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (m_done[k]) begin
                    if (rena) pend[2*k].push_back(read_word(k, addra, m_cyc + p_lat[k]));
                    if (renb) pend[2*k+1].push_back(read_word(k, addrb, m_cyc + p_lat[k]));
                    if (wenb) begin
                        m_mem[k][addrb] = merge32(m_mem[k][addrb], datab, webb);
                        m_kn[k][addrb]  = m_kn[k][addrb] || (webb == 4'hF);
                    end
                end else begin
                    if (m_ready[k] && ld_valid) begin
                        m_mem[k][m_cnt[k]] = ld_data;
                        m_kn[k][m_cnt[k]]  = 1'b1;
                        m_cnt[k]++;
                    end
                    if (m_cnt[k] == p_init[k]) begin
                        m_done[k] = 1'b1; m_ready[k] = 1'b0;
                    end else begin
                        m_ready[k] = 1'b1;
                    end
                end
            end
        end
        m_cyc++;
        for (int j = 0; j < 2*NI; j++) begin
            e_vld[j] = 1'b0;
            if (pend[j].size() > 0 && pend[j][0].due == m_cyc) begin
                r = pend[j].pop_front();
                e_vld[j] = 1'b1; e_q[j] = r.d; e_kn[j] = r.kn;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("u%0d.init_done", k), 32'(init_done_w[k]), 32'(m_done[k]));
                chk($sformatf("u%0d.ld_ready", k), 32'(ld_ready_w[k]), 32'(m_ready[k]));
                chk($sformatf("u%0d.qa_vld", k), 32'(qa_vld_w[k]), 32'(e_vld[2*k]));
                chk($sformatf("u%0d.qb_vld", k), 32'(qb_vld_w[k]), 32'(e_vld[2*k+1]));
                if (e_kn[2*k])   chk($sformatf("u%0d.qa", k), qa_w[k], e_q[2*k]);
                if (e_kn[2*k+1]) chk($sformatf("u%0d.qb", k), qb_w[k], e_q[2*k+1]);
            end
        end
    end

    // init_done rising-edge counter for u0
    int rises = 0;
    bit prev_done = 1'b0;
    initial forever begin
        @(negedge clk);
        if (init_done_w[0] === 1'b1 && !prev_done) rises++;
        prev_done = (init_done_w[0] === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [31:0] load1 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [31:0] load2 [4] = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    logic [31:0] load3 [4] = '{32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3};
    logic [31:0] tp_exp [3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    task automatic idle();
        rena = 1'b0; renb = 1'b0; wenb = 1'b0; webb = 4'h0;
        addra = 6'd0; addrb = 6'd0; datab = 32'h0;
    endtask

    // presents words with a gap every third cycle until n are accepted
    task automatic stream(input logic [31:0] words [4], input int n);
        int got;
        got = 0;
        for (int it = 0; it < 60 && got < n; it++) begin
            @(negedge clk);
            if (it % 3 == 1) begin
                ld_valid = 1'b0;
            end else begin
                ld_valid = 1'b1;
                ld_data  = words[got];
                if (ld_ready_w[0] === 1'b1) got++;
            end
        end
        @(negedge clk);
        ld_valid = 1'b0;
        chk("stream.accepted", 32'(got), 32'(n));
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wenb = 1'b1; addrb = a; datab = d; webb = be;
        @(negedge clk);
        idle();
    endtask

    task automatic rda_u0(input logic [5:0] a, input logic [31:0] exp, input string name);
        rena = 1'b1; addra = a;
        @(negedge clk);
        idle();
        chk({name, ".vld"}, 32'(qa_vld_w[0]), 32'h1);
        chk(name, qa_w[0], exp);
    endtask

    int rises_before;

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_data = 32'h0;
        idle();
        repeat (3) @(negedge clk);
        chk("reset.init_done", 32'(init_done_w[0]), 32'h0);
        chk("reset.ld_ready", 32'(ld_ready_w[0]), 32'h0);
        chk("reset.qa_vld", 32'(qa_vld_w[0]), 32'h0);
        chk("reset.qa", qa_w[1], 32'h0);
        rst = 1'b1;

        // load then run
        stream(load1, 4);
        chk("load.init_done", 32'(init_done_w[0]), 32'h1);
        chk("load.ld_ready", 32'(ld_ready_w[0]), 32'h0);
        chk("init0.init_done", 32'(init_done_w[2]), 32'h1);
        wr(6'd5, 32'h00000000, 4'hF);
        wr(6'd7, 32'h12345678, 4'hF);
        wr(6'd10, 32'hCAFE0010, 4'hF);
        rena = 1'b1; addra = 6'd2;
        @(negedge clk);
        idle();
        chk("rdA2.lat1.vld", 32'(qa_vld_w[0]), 32'h1);
        chk("rdA2.lat1", qa_w[0], 32'h33333333);
        chk("rdA2.lat2.early", 32'(qa_vld_w[1]), 32'h0);
        @(negedge clk);
        chk("rdA2.lat2.vld", 32'(qa_vld_w[1]), 32'h1);
        chk("rdA2.lat2", qa_w[1], 32'h33333333);
        chk("rdA2.lat1.pulse", 32'(qa_vld_w[0]), 32'h0);
        repeat (2) @(negedge clk);

        // byte write
        wr(6'd5, 32'hAABBCCDD, 4'b0101);
        renb = 1'b1; addrb = 6'd5;
        @(negedge clk);
        idle();
        chk("bytewr.qb", qb_w[0], 32'h00BB00DD);
        repeat (2) @(negedge clk);

        // collision on both ports
        rena = 1'b1; addra = 6'd7; renb = 1'b1;
        wenb = 1'b1; addrb = 6'd7; datab = 32'hFFFFFFFF; webb = 4'b0011;
        @(negedge clk);
        idle();
        chk("coll.mode0.qa", qa_w[0], 32'h12345678);
        chk("coll.mode0.qb", qb_w[0], 32'h12345678);
        chk("coll.mode1.lat1.qa", qa_w[2], 32'h1234FFFF);
        @(negedge clk);
        chk("coll.mode1.lat2.qa", qa_w[1], 32'h1234FFFF);
        chk("coll.mode1.lat2.qb", qb_w[1], 32'h1234FFFF);
        rda_u0(6'd7, 32'h1234FFFF, "coll.after");
        repeat (2) @(negedge clk);

        // back-to-back reads, latency 2
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                rena = 1'b1; addra = 6'(i);
            end else begin
                idle();
            end
            @(negedge clk);
            if (i >= 1 && i <= 3) begin
                chk("tp.vld", 32'(qa_vld_w[1]), 32'h1);
                chk("tp.data", qa_w[1], tp_exp[i-1]);
            end else begin
                chk("tp.vld_low", 32'(qa_vld_w[1]), 32'h0);
            end
        end

        // in-flight latency-2 read dropped by reset
        rena = 1'b1; addra = 6'd0;
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst.drop.vld", 32'(qa_vld_w[1]), 32'h0);
        @(negedge clk);

        // mid-load reset with ports gated during LOAD
        rises_before = rises;
        rst = 1'b1;
        rena = 1'b1; addra = 6'd10;
        wenb = 1'b1; addrb = 6'd10; datab = 32'hDEADBEEF; webb = 4'hF;
        stream(load2, 2);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stream(load3, 4);
        idle();
        chk("reload.init_done", 32'(init_done_w[0]), 32'h1);
        repeat (3) @(negedge clk);
        chk("reload.rises", 32'(rises - rises_before), 32'h1);
        rda_u0(6'd0, 32'h000000A0, "reload.w0");
        rda_u0(6'd1, 32'h000000A1, "reload.w1");
        rda_u0(6'd2, 32'h000000A2, "reload.w2");
        rda_u0(6'd3, 32'h000000A3, "reload.w3");
        rda_u0(6'd10, 32'hCAFE0010, "gated.w10");
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
